// File: rtl/fir_block_ctrl.sv
// fir_block_ctrl: block sequencer for the FIR_filter datapath.
// Reads len samples from a synchronous sample RAM, streams them into the filter
// one per clock, and writes each filter output to a result RAM at the index of
// the sample that produced it. Start/done handshake towards the host.
// Optional feature macro: FIR_CTRL_FLUSH_EN -- after the last sample, feed
// TAPS-1 zero samples so the filter tail is also written out (needs TAPS >= 2).
module fir_block_ctrl #(
  parameter int DW   = 16,
  parameter int AW   = 10,
  parameter int LAT  = 1,
  parameter int TAPS = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [AW-1:0] len,
  output logic          busy,
  output logic          done,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data,
  output logic          fir_rst,
  output logic [DW-1:0] fir_in,
  input  logic [DW-1:0] fir_out,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data
);

  // Tag pipeline depth: read issue -> RAM data -> fir_in register -> LAT filter stages.
  localparam int D = 2 + LAT;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FEED,
`ifdef FIR_CTRL_FLUSH_EN
    S_FLUSH,
`endif
    S_DRAIN,
    S_DONE
  } state_t;

  state_t        state_reg, state_next;
  logic [AW-1:0] len_reg, len_next;
  logic          rd_en_reg, rd_en_next;
  logic [AW-1:0] rd_addr_reg, rd_addr_next;
  logic          fir_rst_reg, fir_rst_next;
  logic [DW-1:0] fir_in_reg, fir_in_next;
  logic          rd_vld_reg;
  logic          pipe_v_reg [D];
  logic [AW-1:0] pipe_a_reg [D];
  logic          pipe_early;
  logic          iss_v;
  logic          kill;

`ifdef FIR_CTRL_FLUSH_EN
  localparam int FCW = (TAPS > 2) ? $clog2(TAPS) : 1;
  logic [FCW-1:0] flush_cnt_reg, flush_cnt_next;
`endif

  // A slot is tagged in every cycle that puts a sample (real or flush zero) on its way.
`ifdef FIR_CTRL_FLUSH_EN
  assign iss_v = rd_en_reg | (state_reg == S_FLUSH);
`else
  assign iss_v = rd_en_reg;
`endif

  assign kill = abort && (state_reg != S_IDLE);

  // Any tag still in flight ahead of the write stage.
  always_comb begin
    pipe_early = 1'b0;
    for (int i = 0; i < D - 1; i++) pipe_early = pipe_early | pipe_v_reg[i];
  end

  // Next-state and registered-output decode; abort overrides everything at the end.
  always_comb begin
    state_next   = state_reg;
    len_next     = len_reg;
    rd_en_next   = 1'b0;
    rd_addr_next = rd_addr_reg;
    fir_rst_next = 1'b0;
    fir_in_next  = rd_vld_reg ? rd_data : '0;
`ifdef FIR_CTRL_FLUSH_EN
    flush_cnt_next = flush_cnt_reg;
`endif
    case (state_reg)
      S_IDLE: begin
        if (start && !abort) begin
          len_next = len;
          if (len == '0) begin
            state_next = S_DONE;
          end else begin
            state_next   = S_FEED;
            rd_en_next   = 1'b1;
            rd_addr_next = '0;
            fir_rst_next = 1'b1;
          end
        end
      end
      S_FEED: begin
        rd_addr_next = rd_addr_reg + AW'(1);
        if (rd_addr_reg == len_reg - AW'(1)) begin
`ifdef FIR_CTRL_FLUSH_EN
          state_next     = S_FLUSH;
          flush_cnt_next = '0;
`else
          state_next = S_DRAIN;
`endif
        end else begin
          rd_en_next = 1'b1;
        end
      end
`ifdef FIR_CTRL_FLUSH_EN
      S_FLUSH: begin
        // rd_addr keeps counting so flush tags land at len, len+1, ...
        rd_addr_next = rd_addr_reg + AW'(1);
        if (flush_cnt_reg == FCW'(TAPS - 2)) state_next = S_DRAIN;
        else flush_cnt_next = flush_cnt_reg + FCW'(1);
      end
`endif
      S_DRAIN: begin
        if (pipe_v_reg[D-1] && !pipe_early) state_next = S_DONE;
      end
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (kill) begin
      state_next   = S_IDLE;
      rd_en_next   = 1'b0;
      fir_rst_next = 1'b0;
      fir_in_next  = '0;
    end
  end

  // Control and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      len_reg     <= '0;
      rd_en_reg   <= 1'b0;
      rd_addr_reg <= '0;
      fir_rst_reg <= 1'b0;
      fir_in_reg  <= '0;
      rd_vld_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      len_reg     <= len_next;
      rd_en_reg   <= rd_en_next;
      rd_addr_reg <= rd_addr_next;
      fir_rst_reg <= fir_rst_next;
      fir_in_reg  <= fir_in_next;
      rd_vld_reg  <= rd_en_reg && !kill;
    end
  end

`ifdef FIR_CTRL_FLUSH_EN
  // Flush slot counter.
  always_ff @(posedge clk) begin
    if (rst) flush_cnt_reg <= '0;
    else     flush_cnt_reg <= flush_cnt_next;
  end
`endif

  // Valid/address tag shift pipeline; the last stage lines up with fir_out.
  for (genvar gi = 0; gi < D; gi++) begin : g_tag
    if (gi == 0) begin : g_head
      // Head stage captures the tag issued this cycle.
      always_ff @(posedge clk) begin
        if (rst) begin
          pipe_v_reg[gi] <= 1'b0;
          pipe_a_reg[gi] <= '0;
        end else begin
          pipe_v_reg[gi] <= iss_v && !kill;
          pipe_a_reg[gi] <= rd_addr_reg;
        end
      end
    end else begin : g_body
      // Body stages shift the tag one step towards the write port.
      always_ff @(posedge clk) begin
        if (rst) begin
          pipe_v_reg[gi] <= 1'b0;
          pipe_a_reg[gi] <= '0;
        end else begin
          pipe_v_reg[gi] <= pipe_v_reg[gi-1] && !kill;
          pipe_a_reg[gi] <= pipe_a_reg[gi-1];
        end
      end
    end
  end

  assign busy    = (state_reg == S_FEED) || (state_reg == S_DRAIN)
`ifdef FIR_CTRL_FLUSH_EN
                   || (state_reg == S_FLUSH)
`endif
                   ;
  assign done    = (state_reg == S_DONE);
  assign rd_en   = rd_en_reg;
  assign rd_addr = rd_addr_reg;
  assign fir_rst = fir_rst_reg;
  assign fir_in  = fir_in_reg;
  assign wr_en   = pipe_v_reg[D-1];
  assign wr_addr = pipe_a_reg[D-1];
  assign wr_data = pipe_v_reg[D-1] ? fir_out : '0;

endmodule

// File: tb/tb_fir_block_ctrl.sv
// Testbench for fir_block_ctrl: sample RAM model, 5-tap FIR stand-in with LAT=1
// and coefficients {1,2,3,2,1}, table-driven block runs plus hand sequences.
module tb_fir_block_ctrl;
  localparam int DW = 16, AW = 10, LAT = 1, TAPS = 5;
`ifdef FIR_CTRL_FLUSH_EN
  localparam int NFL = TAPS - 1;
`else
  localparam int NFL = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [AW-1:0] len = '0;
  logic          busy, done, rd_en, fir_rst, wr_en;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [DW-1:0] rd_data = '0;
  logic [DW-1:0] fir_in, wr_data;
  logic [DW-1:0] fir_out = '0;

  fir_block_ctrl #(.DW(DW), .AW(AW), .LAT(LAT), .TAPS(TAPS)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .len(len),
    .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .fir_rst(fir_rst), .fir_in(fir_in), .fir_out(fir_out),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Sample RAM with registered read.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  // Filter stand-in: one register stage, so LAT = 1.
  logic [DW-1:0] dl [4];
  always @(posedge clk) begin
    if (rst || fir_rst) begin
      fir_out <= '0;
      for (int i = 0; i < 4; i++) dl[i] <= '0;
    end else begin
      fir_out <= DW'(32'(fir_in) + 2 * 32'(dl[0]) + 3 * 32'(dl[1]) + 2 * 32'(dl[2]) + 32'(dl[3]));
      dl[0] <= fir_in;
      dl[1] <= dl[0];
      dl[2] <= dl[1];
      dl[3] <= dl[2];
    end
  end

  int n_pass = 0, n_total = 0;
  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  typedef struct {
    int len; int pat; int abort_at; int poke_at;
    int exp_rd; int exp_wr; int exp_done; int exp_rst; int ref_cmp;
  } vec_t;

  // Monitor state for the block in progress.
  bit mon_on = 1'b0;
  int t0 = 0;
  int cur_len, cur_abort, cur_done;
  int rd_cnt, rd_bad, fin_bad, busy_bad, rst_cnt, rst_bad, done_cnt, done_cyc;
  int wa_q[$], wd_q[$], wc_q[$];
  int saved_q[$];

  // Per-cycle observation of the DUT away from the active edge.
  always @(negedge clk) begin : mon
    int rel;
    logic [DW-1:0] e;
    logic eb;
    if (mon_on) begin
      rel = cyc - t0;
      if (rd_en) begin
        if (rd_addr != AW'(rd_cnt) || rel != 1 + rd_cnt) rd_bad++;
        rd_cnt++;
      end
      if (cur_abort > 0 && rel > cur_abort) e = '0;
      else if (rel >= 3 && rel < 3 + cur_len) e = mem[AW'(rel - 3)];
      else e = '0;
      if (fir_in !== e) fin_bad++;
      eb = (cur_len > 0) && (rel >= 1) && ((cur_abort > 0) ? (rel <= cur_abort) : (rel < cur_done));
      if (busy !== eb) busy_bad++;
      if (fir_rst) begin
        rst_cnt++;
        if (rel != 1) rst_bad++;
      end
      if (done) begin
        if (done_cnt == 0) done_cyc = rel;
        done_cnt++;
      end
      if (wr_en) begin
        wa_q.push_back(int'(wr_addr));
        wd_q.push_back(int'(wr_data));
        wc_q.push_back(rel);
      end
    end
  end

  int imp [12] = '{32'h7FFF, 32'hFFFE, 32'h7FFD, 32'hFFFE, 32'h7FFF, 0, 0, 0, 0, 0, 0, 0};

  task automatic run_block(input int idx, input vec_t v);
    int last, rel, bad;
    for (int i = 0; i < (1 << AW); i++)
      mem[i] = (v.pat == 0) ? ((i == 0) ? 16'h7FFF : 16'h0000) : DW'(i * 37 + 5);
    rd_cnt = 0; rd_bad = 0; fin_bad = 0; busy_bad = 0; rst_cnt = 0; rst_bad = 0;
    done_cnt = 0; done_cyc = -1;
    wa_q.delete(); wd_q.delete(); wc_q.delete();
    cur_len = v.len; cur_abort = v.abort_at; cur_done = v.exp_done;
    @(posedge clk); #1;
    start = 1'b1; len = AW'(v.len); t0 = cyc; mon_on = 1'b1;
    last = (v.exp_done >= 0) ? v.exp_done : 40;
    rel = 0;
    while (rel < last) begin
      @(posedge clk); #1;
      rel = cyc - t0;
      start = (v.poke_at > 0 && rel == v.poke_at);
      if (start) len = AW'(3);
      abort = (v.abort_at > 0 && rel == v.abort_at);
    end
    @(negedge clk); #1;
    mon_on = 1'b0; start = 1'b0; abort = 1'b0;
    chk($sformatf("v%0d reads", idx), rd_cnt, v.exp_rd);
    chk($sformatf("v%0d rd_order", idx), rd_bad, 0);
    chk($sformatf("v%0d writes", idx), wa_q.size(), v.exp_wr);
    bad = 0;
    foreach (wa_q[i]) if (wa_q[i] != (i % (1 << AW)) || wc_q[i] != 3 + i + LAT) bad++;
    chk($sformatf("v%0d wr_order", idx), bad, 0);
    chk($sformatf("v%0d done_cyc", idx), done_cyc, v.exp_done);
    chk($sformatf("v%0d done_cnt", idx), done_cnt, (v.exp_done >= 0) ? 1 : 0);
    chk($sformatf("v%0d fir_rst", idx), rst_cnt, v.exp_rst);
    chk($sformatf("v%0d fir_rst_cyc", idx), rst_bad, 0);
    chk($sformatf("v%0d fir_in", idx), fin_bad, 0);
    chk($sformatf("v%0d busy", idx), busy_bad, 0);
    if (v.ref_cmp == 1) begin
      for (int i = 0; i < 8 + NFL; i++)
        chk($sformatf("v%0d imp_data[%0d]", idx, i), (i < wd_q.size()) ? wd_q[i] : -1, imp[i]);
      saved_q = wd_q;
    end else if (v.ref_cmp == 2) begin
      for (int i = 0; i < saved_q.size(); i++)
        chk($sformatf("v%0d repeat_data[%0d]", idx, i), (i < wd_q.size()) ? wd_q[i] : -1, saved_q[i]);
    end
    $display("block v%0d len=%0d: reads=%0d writes=%0d done_cycle=%0d fir_rst=%0d",
             idx, v.len, rd_cnt, wa_q.size(), done_cyc, rst_cnt);
  endtask

  vec_t vecs [8];
  int cnt;

  initial begin
    vecs[0] = '{8,    0, 0, 0, 8,    8 + NFL,    12 + NFL,   1, 1};
    vecs[1] = '{0,    1, 0, 0, 0,    0,          1,          0, 0};
    vecs[2] = '{1,    1, 0, 0, 1,    1 + NFL,    5 + NFL,    1, 0};
    vecs[3] = '{8,    0, 0, 4, 8,    8 + NFL,    12 + NFL,   1, 1};
    vecs[4] = '{1000, 1, 5, 0, 5,    2,          -1,         1, 0};
    vecs[5] = '{3,    1, 0, 0, 3,    3 + NFL,    7 + NFL,    1, 0};
    vecs[6] = '{8,    0, 0, 0, 8,    8 + NFL,    12 + NFL,   1, 2};
    vecs[7] = '{1023, 1, 0, 0, 1023, 1023 + NFL, 1027 + NFL, 1, 0};

    // Reset: two cycles high, outputs quiet during and after.
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    chk("reset_ctrl_in_rst", {busy, done, rd_en, fir_rst, wr_en}, 0);
    chk("reset_bus_in_rst", {|rd_addr, |fir_in, |wr_addr, |wr_data}, 0);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_ctrl_after", {busy, done, rd_en, fir_rst, wr_en}, 0);
    chk("reset_bus_after", {|rd_addr, |fir_in, |wr_addr, |wr_data}, 0);
    $display("reset: busy=%0d done=%0d rd_en=%0d wr_en=%0d", busy, done, rd_en, wr_en);

    for (int i = 0; i < 8; i++) run_block(i, vecs[i]);

    // start and abort together in IDLE: nothing happens.
    @(posedge clk); #1;
    start = 1'b1; abort = 1'b1; len = AW'(5);
    cnt = 0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      cnt += int'(busy | rd_en | done | fir_rst | wr_en);
      #1 start = 1'b0; abort = 1'b0;
    end
    chk("start_abort_idle", cnt, 0);
    $display("start+abort in idle: active cycles=%0d", cnt);

    // rst in the middle of a block: everything quiet, then a clean restart.
    @(posedge clk); #1;
    start = 1'b1; len = AW'(8);
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_ctrl", {busy, done, rd_en, fir_rst, wr_en}, 0);
    chk("midrst_bus", {|rd_addr, |fir_in, |wr_addr}, 0);
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      cnt += int'(busy | rd_en | wr_en | done);
    end
    chk("midrst_quiet", cnt, 0);
    $display("mid-block rst: active cycles after=%0d", cnt);
    run_block(8, '{2, 1, 0, 0, 2, 2 + NFL, 6 + NFL, 1, 0});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
